systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_pkg.sv | 22 ++
 rtl/systolic_feeder.sv | 166 ++++++++++++++++
 tb/tb_systolic_feeder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// =====================================================================
// systolic_pkg: shared constants and state encoding for systolic_feeder.
// Rev 1.0
// =====================================================================
`default_nettype none

package systolic_pkg;

    localparam int DATAWIDTH = 8;
    localparam int N         = 3;
    localparam int BEATS     = 2 * N - 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FEED      = 2'd1,
        FLUSH     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/systolic_feeder.sv
// =====================================================================
// systolic_feeder: skews a 3x3 A/B matrix pair into row/column streams.
// Rev 1.0
// =====================================================================
`default_nettype none

module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATAWIDTH = systolic_pkg::DATAWIDTH,
    parameter int TIMEOUT   = 16
) (
    input  logic                       CLK,
    input  logic                       RSTn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*N*DATAWIDTH-1:0]   a_mat,
    input  logic [N*N*DATAWIDTH-1:0]   b_mat,
    output logic [DATAWIDTH-1:0]       A0,
    output logic [DATAWIDTH-1:0]       A1,
    output logic [DATAWIDTH-1:0]       A2,
    output logic [DATAWIDTH-1:0]       B0,
    output logic [DATAWIDTH-1:0]       B1,
    output logic [DATAWIDTH-1:0]       B2,
    output logic                       start,
    input  logic                       Done,
    output logic                       busy,
    output logic                       err
);

    localparam int              MAT_W     = N * N * DATAWIDTH;
    localparam int              WCW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0]  WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [2:0]      LAST_BEAT = 3'(BEATS - 1);

    state_t               state;
    state_t               state_nx;
    logic [2:0]           beat;
    logic [2:0]           beat_nx;
    logic [WCW-1:0]       wait_cnt;
    logic [WCW-1:0]       wait_cnt_nx;
    logic                 capture;
    logic                 err_nx;
    logic [MAT_W-1:0]     a_q;
    logic [MAT_W-1:0]     b_q;
    logic [MAT_W-1:0]     a_src;
    logic [MAT_W-1:0]     b_src;
    logic [DATAWIDTH-1:0] a_nx [N];
    logic [DATAWIDTH-1:0] b_nx [N];

    // Element (r,c) of a packed matrix, or zero when the index falls off the edge.
    function automatic logic [DATAWIDTH-1:0] skew_elem(input logic [MAT_W-1:0] m,
                                                       input int r, input int c);
        logic [DATAWIDTH-1:0] e;
        e = '0;
        if (r >= 0 && r < N && c >= 0 && c < N) begin
            for (int k = 0; k < N * N; k++) begin
                if (k == r * N + c) e = m[k*DATAWIDTH +: DATAWIDTH];
            end
        end
        return e;
    endfunction

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= IDLE;
            beat     <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            beat     <= beat_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        beat_nx     = beat;
        wait_cnt_nx = wait_cnt;
        capture     = 1'b0;
        err_nx      = 1'b0;
        case (state)
            IDLE: begin
                wait_cnt_nx = '0;
                if (in_valid && in_ready) begin
                    state_nx = FEED;
                    beat_nx  = '0;
                    capture  = 1'b1;
                end
            end
            FEED: begin
                if (beat == LAST_BEAT) begin
                    state_nx = FLUSH;
                    beat_nx  = '0;
                end else begin
                    beat_nx = beat + 3'd1;
                end
            end
            FLUSH: begin
                state_nx    = WAIT_DONE;
                wait_cnt_nx = '0;
            end
            WAIT_DONE: begin
                // Done wins over a coinciding timeout.
                if (Done) begin
                    state_nx = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end else begin
                    wait_cnt_nx = wait_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are computed from the next state so beat 0 appears one cycle after transfer.
    always_comb begin
        a_src = capture ? a_mat : a_q;
        b_src = capture ? b_mat : b_q;
        for (int i = 0; i < N; i++) begin
            a_nx[i] = '0;
            b_nx[i] = '0;
            if (state_nx == FEED) begin
                a_nx[i] = skew_elem(a_src, i, int'(beat_nx) - i);
                b_nx[i] = skew_elem(b_src, int'(beat_nx) - i, i);
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            a_q      <= '0;
            b_q      <= '0;
            A0       <= '0;
            A1       <= '0;
            A2       <= '0;
            B0       <= '0;
            B1       <= '0;
            B2       <= '0;
            start    <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            if (capture) begin
                a_q <= a_mat;
                b_q <= b_mat;
            end
            A0       <= a_nx[0];
            A1       <= a_nx[1];
            A2       <= a_nx[2];
            B0       <= b_nx[0];
            B1       <= b_nx[1];
            B2       <= b_nx[2];
            start    <= (state_nx != IDLE);
            busy     <= (state_nx != IDLE);
            err      <= err_nx;
            in_ready <= (state_nx == IDLE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_systolic_feeder.sv
// =====================================================================
// tb_systolic_feeder: directed self-checking bench for systolic_feeder.
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_systolic_feeder;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] a_mat;
    logic [71:0] b_mat;
    logic [7:0]  A0, A1, A2, B0, B1, B2;
    logic        start;
    logic        Done;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Row-major packing: top byte is element [2][2].
    localparam logic [71:0] MA1 = {8'd5, 8'd2, 8'd3, 8'd3, 8'd5, 8'd2, 8'd2, 8'd4, 8'd3};
    localparam logic [71:0] MB1 = {8'd5, 8'd2, 8'd3, 8'd3, 8'd5, 8'd2, 8'd2, 8'd4, 8'd3};
    localparam logic [71:0] MA2 = {8'd13, 8'd12, 8'd11, 8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd1};
    localparam logic [71:0] MB2 = {8'd22, 8'd21, 8'd20, 8'd19, 8'd18, 8'd17, 8'd16, 8'd15, 8'd14};

    logic [47:0] exp1 [5];

    systolic_feeder #(
        .DATAWIDTH (8),
        .TIMEOUT   (16)
    ) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_mat    (a_mat),
        .b_mat    (b_mat),
        .A0       (A0),
        .A1       (A1),
        .A2       (A2),
        .B0       (B0),
        .B1       (B1),
        .B2       (B2),
        .start    (start),
        .Done     (Done),
        .busy     (busy),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] beat6(input int a0, input int a1, input int a2,
                                          input int b0, input int b1, input int b2);
        return {8'(a0), 8'(a1), 8'(a2), 8'(b0), 8'(b1), 8'(b2)};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [47:0] streams();
        return {A0, A1, A2, B0, B1, B2};
    endfunction

    function automatic logic [51:0] all_outs();
        return {A0, A1, A2, B0, B1, B2, start, busy, err, in_ready};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp1[0] = beat6(3, 0, 0, 3, 0, 0);
        exp1[1] = beat6(4, 2, 0, 2, 4, 0);
        exp1[2] = beat6(2, 5, 3, 3, 5, 2);
        exp1[3] = beat6(0, 3, 2, 0, 2, 3);
        exp1[4] = beat6(0, 0, 5, 0, 0, 5);

        RSTn     = 1'b0;
        in_valid = 1'b0;
        Done     = 1'b0;
        a_mat    = '0;
        b_mat    = '0;
        tick();
        tick();
        check("reset_outs", all_outs(), 52'd0);
        #2 RSTn = 1'b1;
        #1 check("ready_before_edge", in_ready, 1'b0);
        tick();
        check("ready_after_release", in_ready, 1'b1);
        check("busy_idle", busy, 1'b0);

        // Pair 1, with competing pair 2 held on the inputs throughout
        a_mat    = MA1;
        b_mat    = MB1;
        in_valid = 1'b1;
        tick();
        a_mat = MA2;
        b_mat = MB2;
        check("start_beat0", start, 1'b1);
        check("ready_feed", in_ready, 1'b0);
        for (int t = 0; t < 5; t++) begin
            check($sformatf("beat%0d", t), streams(), exp1[t]);
            Done = (t == 2);
            tick();
        end
        Done = 1'b0;
        check("flush_data", streams(), 48'd0);
        check("flush_start", start, 1'b1);
        tick();
        check("wait_data", streams(), 48'd0);
        check("wait_start", {start, busy}, 2'b11);
        repeat (3) tick();
        Done = 1'b1;
        tick();
        Done = 1'b0;
        check("done_start", start, 1'b0);
        check("done_ready", in_ready, 1'b1);
        check("done_busy", busy, 1'b0);
        tick();
        in_valid = 1'b0;
        check("b2b_start", start, 1'b1);
        check("b2b_beat0", streams(), beat6(1, 0, 0, 14, 0, 0));
        tick();
        tick();
        check("b2b_beat2", streams(), beat6(7, 9, 11, 20, 18, 16));

        // Asynchronous reset mid-FEED
        #2 RSTn = 1'b0;
        #1 check("async_reset", all_outs(), 52'd0);
        tick();
        check("reset_held", all_outs(), 52'd0);
        #2 RSTn = 1'b1;
        tick();
        check("post_reset_ready", {busy, in_ready}, 2'b01);
        tick();
        check("no_beats_after_reset", {streams(), start}, 49'd0);

        // Timeout without Done
        a_mat    = MA1;
        b_mat    = MB1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        tick();
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("timeout_err_k%0d", k), err, (k == 16));
        end
        check("timeout_idle", {busy, in_ready, start}, 3'b010);
        tick();
        check("err_one_cycle", err, 1'b0);

        // Done coinciding with the final wait cycle
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        tick();
        repeat (15) tick();
        Done = 1'b1;
        tick();
        Done = 1'b0;
        check("done_vs_timeout_err", err, 1'b0);
        check("done_vs_timeout_idle", {busy, in_ready}, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
